clock_works: RTL and testbench
==============================

CLOCK_WORKS -- requirements
Module: clock_works

Interface
REQ-001 SHALL have parameter SLOW, default 0: clock division exponent; divided clock period = 2^(SLOW+1) CLK cycles when SLOW>0.
REQ-002 SHALL have parameter RESET_HOLD, default 2, legal range 1..255: number of divided-clock periods resetn stays low after reset release.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all internal state is clocked on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, output, 1 bit: divided clock for downstream logic.
REQ-006 SHALL have port resetn, output, 1 bit: active-low reset for downstream logic, valid in the clk domain.

Function
REQ-007 SHALL contain a free-running divider counter, SLOW+1 bits wide, incrementing by 1 every CLK edge and wrapping from all-ones to 0.
REQ-008 SHALL drive clk from the counter MSB when SLOW>0: low for counts 0..2^SLOW-1, high for 2^SLOW..2^(SLOW+1)-1, 50% duty.
REQ-009 SHALL drive clk directly from CLK when SLOW=0, with no register or logic in the path.
REQ-010 SHALL define a wrap event as the CLK edge on which the counter goes from all-ones to 0, i.e. the clk falling edge; with SLOW=0 every CLK edge is a wrap event.
REQ-011 SHALL contain a saturating hold counter, 8 bits wide, that increments on each wrap event while below RESET_HOLD.
REQ-012 SHALL register resetn in the CLK domain and set it to 1 on the wrap event that brings the hold counter to RESET_HOLD.
REQ-013 SHALL change resetn only on wrap events, never mid-phase, so it is stable at every clk rising edge.
REQ-014 SHALL keep resetn at 1 indefinitely after release until RESET is asserted again.
REQ-015 SHALL let a RESET asserted mid-operation act on the next CLK edge: counter 0, clk low, hold counter 0, resetn 0. A truncated clk high phase is acceptable.
REQ-016 SHALL hold all state at reset values for as long as RESET is sampled high, with no counting.

Reset
REQ-017 SHALL, on a CLK edge with RESET=1, set the divider counter to 0, the hold counter to 0 and resetn to 0; clk is then low for SLOW>0.
REQ-018 SHALL give all registers the same values as initial (power-up) values, so downstream logic sees a power-on reset without RESET ever being asserted.
REQ-019 SHALL produce exactly RESET_HOLD*2^(SLOW+1) CLK edges between the first edge sampling RESET=0 and the edge that sets resetn=1, inclusive of both edges, for SLOW>0.

Structure
REQ-020 SHALL be a single self-contained module with no shared package; widths derive locally from SLOW.
REQ-021 SHALL keep the reset-hold logic in one always block; it MAY be split into a sub-module named clock_works_reset_hold with inputs CLK, RESET and wrap, and output resetn.
REQ-022 SHALL contain no combinational path from RESET to clk or resetn.

Verification
REQ-023 SLOW=2, RESET low long-term -> clk period 8 CLK cycles, 4 high and 4 low, rising when the counter reaches 4.
REQ-024 SLOW=2, RESET_HOLD=2, RESET high 3 cycles then low -> resetn=0 during reset; resetn=1 on the 16th CLK edge after release, coincident with the clk falling edge.
REQ-025 SLOW=0, RESET_HOLD=2, RESET pulse -> clk identical to CLK; resetn=1 on the 2nd CLK edge after release.
REQ-026 SLOW=2, RESET reasserted 2 cycles into a clk high phase -> next edge: clk=0, resetn=0; full 16-edge hold sequence restarts after release.
REQ-027 Power-up with RESET never asserted, SLOW=2, RESET_HOLD=3 -> resetn=0 for the first 23 edges, 1 from the 24th edge onward.
REQ-028 Long run of 10,000 cycles after release -> resetn stays 1, clk period constant, no glitches at counter wrap.

Source files
------------

// File: rtl/clock_works_reset_hold.sv
// Reset stretcher: keeps resetn low for RESET_HOLD divided-clock periods after RESET drops.
// resetn only moves on wrap events, so it is stable at every divided-clock rising edge.
module clock_works_reset_hold #(
    parameter int RESET_HOLD = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic wrap,
    output logic resetn
);

    localparam logic [7:0] HOLD_MAX  = 8'(RESET_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);

    // Power-up values match the reset values so downstream logic gets a power-on reset for free.
    logic [7:0] hold_count = '0;
    logic       resetn_q   = 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_count <= '0;
            resetn_q   <= 1'b0;
        end else if (wrap && (hold_count < HOLD_MAX)) begin
            hold_count <= hold_count + 8'd1;
            if (hold_count == HOLD_LAST) begin
                resetn_q <= 1'b1;
            end
        end
    end

    assign resetn = resetn_q;

endmodule

// File: rtl/clock_works.sv
// Clock divider plus synchronous reset generator for a divided-clock domain.
// SLOW=0 passes CLK straight through; SLOW>0 divides by 2^(SLOW+1) with 50% duty.
module clock_works #(
    parameter int SLOW       = 0,
    parameter int RESET_HOLD = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    logic wrap;

    generate
        if (SLOW == 0) begin : g_direct
            // Undivided: every CLK edge counts as a wrap for the hold counter.
            assign clk  = CLK;
            assign wrap = 1'b1;
        end else begin : g_divided
            logic [SLOW:0] count = '0;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            // The all-ones to zero step is exactly the falling edge of clk.
            assign clk  = count[SLOW];
            assign wrap = &count;
        end
    endgenerate

    clock_works_reset_hold #(
        .RESET_HOLD(RESET_HOLD)
    ) u_reset_hold (
        .CLK   (CLK),
        .RESET (RESET),
        .wrap  (wrap),
        .resetn(resetn)
    );

endmodule

// File: tb/tb_clock_works.sv
// Scoreboard bench for clock_works: three instances (SLOW=2/HOLD=2, SLOW=0/HOLD=2, power-up SLOW=2/HOLD=3).
// Stimulus pushes closed-form expectations per CLK edge; a monitor pops and compares just after each edge.
module tb_clock_works;

    logic CLK = 1'b0;
    logic rst_ab = 1'b1;
    logic rst_c = 1'b0;

    logic clk_a, resetn_a;
    logic clk_b, resetn_b;
    logic clk_c, resetn_c;

    int total = 0;
    int bad = 0;
    int edge_k = 0;
    int since_release = 0;

    typedef struct {
        logic a_clk;
        logic a_rn;
        logic b_clk;
        logic b_rn;
        logic c_clk;
        logic c_rn;
        int   k;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    clock_works #(.SLOW(2), .RESET_HOLD(2)) dut_a (
        .CLK   (CLK),
        .RESET (rst_ab),
        .clk   (clk_a),
        .resetn(resetn_a)
    );

    clock_works #(.SLOW(0), .RESET_HOLD(2)) dut_b (
        .CLK   (CLK),
        .RESET (rst_ab),
        .clk   (clk_b),
        .resetn(resetn_b)
    );

    clock_works #(.SLOW(2), .RESET_HOLD(3)) dut_c (
        .CLK   (CLK),
        .RESET (rst_c),
        .clk   (clk_c),
        .resetn(resetn_c)
    );

    task automatic check_output(input string name, input int k, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s edge %0d: got %b expected %b", name, k, act, exp);
        end
    endtask

    // Drive RESET for the coming edge and queue what all three instances must show after it.
    task automatic apply_stimulus(input logic rst);
        exp_t e;
        rst_ab = rst;
        edge_k++;
        if (rst) since_release = 0;
        else since_release++;
        if (rst) begin
            e.a_clk = 1'b0;
            e.a_rn  = 1'b0;
            e.b_rn  = 1'b0;
        end else begin
            e.a_clk = ((since_release % 8) >= 4);
            e.a_rn  = (since_release >= 16);
            e.b_rn  = (since_release >= 2);
        end
        e.b_clk = 1'b1;
        e.c_clk = ((edge_k % 8) >= 4);
        e.c_rn  = (edge_k >= 24);
        e.k     = edge_k;
        sb_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output("a_clk", e.k, clk_a, e.a_clk);
                check_output("a_resetn", e.k, resetn_a, e.a_rn);
                check_output("b_clk", e.k, clk_b, e.b_clk);
                check_output("b_resetn", e.k, resetn_b, e.b_rn);
                check_output("c_clk", e.k, clk_c, e.c_clk);
                check_output("c_resetn", e.k, resetn_c, e.c_rn);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic empty_ok;
        #1;
        check_output("powerup_a_clk", 0, clk_a, 1'b0);
        check_output("powerup_a_resetn", 0, resetn_a, 1'b0);
        check_output("powerup_b_resetn", 0, resetn_b, 1'b0);
        check_output("powerup_c_clk", 0, clk_c, 1'b0);
        check_output("powerup_c_resetn", 0, resetn_c, 1'b0);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1);
        for (int i = 0; i < 46; i++) apply_stimulus(1'b0);
        // Now two edges into a clk high phase of dut_a: reassert and restart the hold sequence.
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1);
        for (int i = 0; i < 10040; i++) apply_stimulus(1'b0);

        @(posedge CLK);
        #2;
        empty_ok = (sb_q.size() == 0);
        check_output("scoreboard_drained", edge_k, empty_ok, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
